lsu_mem_port: RTL and testbench
===============================

LSU_MEM_PORT -- requirements
Module: lsu_mem_port

Interface
REQ-001 SHALL use one clock; reset is synchronous and active-high.
REQ-002 SHALL have parameter: TIMEOUT_CYCLES, default 255, ISSUE cycles without mem_ready before an error response (1..255).
REQ-003 Ports:
- clk  in  1  clock
- reset  in  1  sync active-high reset
- req_valid  in  1  core access request
- req_ready  out  1  LSU idle, accepts request
- req_we  in  1  1=store, 0=load
- req_funct3  in  3  RV32I load/store funct3
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  extended load data; 0 for stores/errors
- resp_err  out  1  bad funct3 or timeout
- resp_misaligned  out  1  misaligned access, no memory access
- mem_req  out  1  memory request, held until mem_ready
- mem_we  out  1  memory write enable
- mem_addr  out  32  word address, {req_addr[31:2],2'b00}
- mem_be  out  4  byte-lane enables, little-endian
- mem_wdata  out  32  lane-replicated store data
- mem_ready  in  1  memory completes the access this cycle
- mem_rdata  in  32  read word, valid when mem_ready=1

Function
REQ-004 SHALL implement FSM IDLE, ISSUE, RESP; req_ready=1 only in IDLE.
REQ-005 SHALL capture we/funct3/addr/wdata on req_valid&req_ready; these registers SHALL stay stable until the return to IDLE.
REQ-006 IDLE->ISSUE on acceptance of a legal request; IDLE->RESP on acceptance of an illegal one, with no mem_req.
REQ-007 Legal funct3: loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores 000 SB, 001 SH, 010 SW; all others SHALL give resp_err=1.
REQ-008 ISSUE SHALL drive mem_req=1 with constant mem_we/mem_addr/mem_be/mem_wdata; mem_ready=1 SHALL move to RESP and latch mem_rdata.
REQ-009 ISSUE SHALL count cycles from 0; count reaching TIMEOUT_CYCLES without mem_ready SHALL move to RESP with resp_err=1 and resp_rdata=0.
REQ-010 RESP SHALL assert resp_valid for exactly one cycle, then go to IDLE; minimum latency is accept(c0), ISSUE+mem_ready(c1), resp_valid(c2).
REQ-011 Lanes: byte be=1<<addr[1:0]; half be=addr[1]?1100:0011; word be=1111; loads SHALL drive the same be.
REQ-012 Stores SHALL replicate the byte x4 (SB) or the halfword x2 (SH); SW passes req_wdata through.
REQ-013 Loads SHALL extract the selected lane: LB/LH sign-extend, LBU/LHU zero-extend.
REQ-014 resp_rdata/resp_err/resp_misaligned SHALL be valid only while resp_valid=1 and SHALL be 0 otherwise.
REQ-015 A mem_ready arriving on the same cycle the timeout count hits SHALL take priority: normal completion, resp_err=0.

Reset
REQ-016 Reset SHALL force IDLE and clear the counter; req_ready=1, and all other outputs 0.
REQ-017 Reset during ISSUE or RESP SHALL abort the access with no resp_valid; mem_req drops the next cycle.

Configuration
REQ-018 With LSU_MISALIGN_TRAP_EN defined, SHALL flag misaligned accesses (half with addr[0]=1, word with addr[1:0]!=0): IDLE->RESP, resp_misaligned=1, no mem_req.
REQ-019 Without LSU_MISALIGN_TRAP_EN, SHALL ignore the offending low address bits (half uses addr[1] only, word forces lane 0) and tie resp_misaligned to 0.

Structure
REQ-020 SHALL place lsu_state_t and the load/store funct3 constants in the shared types package (types.svh).
REQ-021 SHALL place lane selection, replication and extension in a combinational sub-module lsu_lane_align; the FSM and counter stay in lsu_mem_port.

Verification
REQ-022 LB addr=0x103, mem_rdata=0x80FF_1234 -> mem_be=1000, resp_rdata=0xFFFF_FF80, resp_valid in cycle 2.
REQ-023 SH addr=0x202, wdata=0x0000_BEEF -> mem_be=1100, mem_wdata=0xBEEF_BEEF, mem_we=1, resp_rdata=0.
REQ-024 LW with mem_ready held low, TIMEOUT_CYCLES=4 -> mem_req for 4 cycles, then resp_valid with resp_err=1, resp_rdata=0.
REQ-025 funct3=011 load -> no mem_req, resp_valid one cycle after accept, resp_err=1.
REQ-026 LW addr=0x101: macro on -> resp_misaligned=1, no mem_req; macro off -> mem_addr=0x100, mem_be=1111.
REQ-027 Reset asserted during ISSUE -> no resp_valid, req_ready=1 after reset; next LBU addr=0x0, rdata=0xFF -> resp_rdata=0x0000_00FF.

Source files
------------

// File: rtl/lsu_mem_port_pkg.sv
// ---------------------------------------------------------------------------
// lsu_mem_port_pkg
// Shared types for the load/store unit memory port:
//   - lsu_state_t       : FSM states of the port (IDLE, ISSUE, RESP)
//   - F3_* constants    : RV32I load/store funct3 encodings
//   - SZ_* constants    : access size carried in funct3[1:0]
//   - funct3_legal()    : is this funct3 a legal load/store encoding
//   - is_misaligned()   : does the address break natural alignment
// ---------------------------------------------------------------------------
package lsu_mem_port_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_RESP  = 2'd2
   } lsu_state_t;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   // Stores only know the three signed-size encodings; loads add the two
   // unsigned variants. Everything else is reported as an error response.
   function automatic logic funct3_legal(input logic we, input logic [2:0] f3);
      logic ok;
      ok = 1'b0;
      if (we) begin
         case (f3)
            F3_SB, F3_SH, F3_SW: ok = 1'b1;
            default:             ok = 1'b0;
         endcase
      end else begin
         case (f3)
            F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: ok = 1'b1;
            default:                             ok = 1'b0;
         endcase
      end
      return ok;
   endfunction

   // Halfwords need an even address, words need a word-aligned address.
   function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] addr_lo);
      logic bad;
      bad = 1'b0;
      if (f3[1:0] == SZ_HALF && addr_lo[0]) begin
         bad = 1'b1;
      end
      if (f3[1:0] == SZ_WORD && addr_lo != 2'b00) begin
         bad = 1'b1;
      end
      return bad;
   endfunction

endpackage

// File: rtl/lsu_mem_port_lane_align.sv
// ---------------------------------------------------------------------------
// lsu_lane_align
// Purely combinational byte-lane logic for the LSU memory port.
// Ports:
//   funct3    in  3   captured load/store funct3
//   addr_lo   in  2   captured byte offset within the word
//   wdata     in  32  right-aligned store data
//   rdata     in  32  raw word returned by memory
//   be        out 4   little-endian byte-lane enables
//   wdata_rep out 32  store data replicated across all lanes
//   rdata_ext out 32  selected load lane, sign- or zero-extended
// Halfword lanes only look at addr_lo[1] and words always use lane 0, so the
// offending low bits of a misaligned access are simply ignored here.
// ---------------------------------------------------------------------------
module lsu_lane_align
   import lsu_mem_port_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] wdata,
   input  logic [31:0] rdata,
   output logic [3:0]  be,
   output logic [31:0] wdata_rep,
   output logic [31:0] rdata_ext
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // Decode the access size once and derive lane enables, replicated store
   // data and the extended load value. funct3[2] marks the unsigned loads.
   always_comb begin
      be        = 4'b0000;
      wdata_rep = 32'h0;
      rdata_ext = 32'h0;
      byte_sel  = rdata[{addr_lo, 3'b000} +: 8];
      half_sel  = addr_lo[1] ? rdata[31:16] : rdata[15:0];
      case (funct3[1:0])
         SZ_BYTE: begin
            be        = 4'b0001 << addr_lo;
            wdata_rep = {4{wdata[7:0]}};
            rdata_ext = funct3[2] ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
         end
         SZ_HALF: begin
            be        = addr_lo[1] ? 4'b1100 : 4'b0011;
            wdata_rep = {2{wdata[15:0]}};
            rdata_ext = funct3[2] ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
         end
         SZ_WORD: begin
            be        = 4'b1111;
            wdata_rep = wdata;
            rdata_ext = rdata;
         end
         default: begin
            be        = 4'b0000;
            wdata_rep = 32'h0;
            rdata_ext = 32'h0;
         end
      endcase
   end

endmodule

// File: rtl/lsu_mem_port.sv
// ---------------------------------------------------------------------------
// lsu_mem_port
// Single-outstanding load/store port between the core and a word-wide memory.
// Parameter:
//   TIMEOUT_CYCLES  ISSUE cycles without mem_ready before an error (1..255)
// Ports:
//   clk, reset                clock, synchronous active-high reset
//   req_valid/req_ready       core request handshake (ready only when idle)
//   req_we/req_funct3         store flag and RV32I funct3
//   req_addr/req_wdata        byte address, right-aligned store data
//   resp_valid                one-cycle completion pulse
//   resp_rdata                extended load data (0 for stores/errors)
//   resp_err                  illegal funct3 or memory timeout
//   resp_misaligned           misaligned access trapped, no memory access
//   mem_req/mem_we            memory request (held until mem_ready), write
//   mem_addr/mem_be           word address, byte-lane enables
//   mem_wdata                 lane-replicated store data
//   mem_ready/mem_rdata       memory completion and read word
// Build option:
//   LSU_MISALIGN_TRAP_EN  when defined, misaligned half/word accesses go
//                         straight to a response with resp_misaligned=1;
//                         otherwise the low address bits are ignored.
// ---------------------------------------------------------------------------
module lsu_mem_port
   import lsu_mem_port_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic        resp_misaligned,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_wdata,
   input  logic        mem_ready,
   input  logic [31:0] mem_rdata
);

   localparam logic [8:0] TIMEOUT_LIMIT = 9'(TIMEOUT_CYCLES);

   lsu_state_t  state_q, state_d;
   logic        we_q, we_d;
   logic [2:0]  funct3_q, funct3_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] rdata_q, rdata_d;
   logic [7:0]  count_q, count_d;
   logic        err_q, err_d;
   logic        mis_q, mis_d;

   logic        misalign_hit;
   logic        in_issue;
   logic        in_resp;
   logic [3:0]  lane_be;
   logic [31:0] lane_wdata;
   logic [31:0] lane_rdata;

   // The misalignment trap is a build-time option; without it nothing is
   // ever flagged and the lane logic quietly drops the offending bits.
`ifdef LSU_MISALIGN_TRAP_EN
   assign misalign_hit = is_misaligned(req_funct3, req_addr[1:0]);
`else
   assign misalign_hit = 1'b0;
`endif

   // Next-state logic. The request fields are captured only on acceptance
   // and then held untouched until we are back in IDLE, so every memory-side
   // output stays constant for the whole ISSUE phase. In ISSUE a mem_ready
   // always wins over a timeout landing on the same cycle.
   always_comb begin
      state_d  = state_q;
      we_d     = we_q;
      funct3_d = funct3_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      rdata_d  = rdata_q;
      count_d  = count_q;
      err_d    = err_q;
      mis_d    = mis_q;
      case (state_q)
         ST_IDLE: begin
            count_d = 8'd0;
            if (req_valid) begin
               we_d     = req_we;
               funct3_d = req_funct3;
               addr_d   = req_addr;
               wdata_d  = req_wdata;
               rdata_d  = 32'h0;
               if (!funct3_legal(req_we, req_funct3)) begin
                  err_d   = 1'b1;
                  mis_d   = 1'b0;
                  state_d = ST_RESP;
               end else if (misalign_hit) begin
                  err_d   = 1'b0;
                  mis_d   = 1'b1;
                  state_d = ST_RESP;
               end else begin
                  err_d   = 1'b0;
                  mis_d   = 1'b0;
                  state_d = ST_ISSUE;
               end
            end
         end
         ST_ISSUE: begin
            if (mem_ready) begin
               rdata_d = mem_rdata;
               state_d = ST_RESP;
            end else if (({1'b0, count_q} + 9'd1) == TIMEOUT_LIMIT) begin
               err_d   = 1'b1;
               rdata_d = 32'h0;
               state_d = ST_RESP;
            end else begin
               count_d = count_q + 8'd1;
            end
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // All state lives here. Reset drops any access in flight on the spot, so
   // an aborted request never produces a response.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         we_q     <= 1'b0;
         funct3_q <= 3'b000;
         addr_q   <= 32'h0;
         wdata_q  <= 32'h0;
         rdata_q  <= 32'h0;
         count_q  <= 8'd0;
         err_q    <= 1'b0;
         mis_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         we_q     <= we_d;
         funct3_q <= funct3_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         rdata_q  <= rdata_d;
         count_q  <= count_d;
         err_q    <= err_d;
         mis_q    <= mis_d;
      end
   end

   lsu_lane_align u_lane_align (
      .funct3    (funct3_q),
      .addr_lo   (addr_q[1:0]),
      .wdata     (wdata_q),
      .rdata     (rdata_q),
      .be        (lane_be),
      .wdata_rep (lane_wdata),
      .rdata_ext (lane_rdata)
   );

   // Outputs are decoded straight from registered state, and everything on
   // the memory side and the response side is forced to zero outside of the
   // phase where it means something.
   always_comb begin
      in_issue        = (state_q == ST_ISSUE);
      in_resp         = (state_q == ST_RESP);
      req_ready       = (state_q == ST_IDLE);
      mem_req         = in_issue;
      mem_we          = in_issue & we_q;
      mem_addr        = in_issue ? {addr_q[31:2], 2'b00} : 32'h0;
      mem_be          = in_issue ? lane_be : 4'b0000;
      mem_wdata       = (in_issue && we_q) ? lane_wdata : 32'h0;
      resp_valid      = in_resp;
      resp_err        = in_resp & err_q;
      resp_misaligned = in_resp & mis_q;
      resp_rdata      = (in_resp && !we_q && !err_q && !mis_q) ? lane_rdata : 32'h0;
   end

endmodule

// File: tb/tb_lsu_mem_port.sv
// ---------------------------------------------------------------------------
// tb_lsu_mem_port
// Self-checking bench for lsu_mem_port (TIMEOUT_CYCLES = 4). A transaction-
// level model derives the expected lanes, store data, load value, error and
// latency of each directed request; a compare process checks the DUT
// outputs against it on every falling edge, and the directed sequence pins
// the model with literal values. Honours LSU_MISALIGN_TRAP_EN.
// ---------------------------------------------------------------------------
module tb_lsu_mem_port;

   localparam int TMO = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic        resp_misaligned;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic        mem_ready;
   logic [31:0] mem_rdata;

   int n_checks = 0;
   int n_fail   = 0;
   logic chk_en = 1'b0;

   logic        exp_we;
   logic [31:0] exp_addr;
   logic [3:0]  exp_be;
   logic [31:0] exp_wdata;
   logic [31:0] exp_rdata;
   logic        exp_err;
   logic        exp_mis;

   logic [3:0]  cap_be;
   logic [31:0] cap_addr;
   logic [31:0] cap_wdata;
   logic        cap_we;
   logic [31:0] cap_rdata;
   logic        cap_err;
   logic        cap_mis;
   int          cap_cycles;

   lsu_mem_port #(.TIMEOUT_CYCLES(TMO)) dut (
      .clk             (clk),
      .reset           (reset),
      .req_valid       (req_valid),
      .req_ready       (req_ready),
      .req_we          (req_we),
      .req_funct3      (req_funct3),
      .req_addr        (req_addr),
      .req_wdata       (req_wdata),
      .resp_valid      (resp_valid),
      .resp_rdata      (resp_rdata),
      .resp_err        (resp_err),
      .resp_misaligned (resp_misaligned),
      .mem_req         (mem_req),
      .mem_we          (mem_we),
      .mem_addr        (mem_addr),
      .mem_be          (mem_be),
      .mem_wdata       (mem_wdata),
      .mem_ready       (mem_ready),
      .mem_rdata       (mem_rdata)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Continuous comparison against the transaction model on every falling
   // edge: memory outputs must match while mem_req is up and be quiet
   // otherwise; response fields must match while resp_valid and be zero
   // otherwise.
   always @(negedge clk) begin
      if (chk_en && !reset) begin
         if (mem_req) begin
            checkOutput("mem_we", {31'b0, mem_we}, {31'b0, exp_we});
            checkOutput("mem_addr", mem_addr, exp_addr);
            checkOutput("mem_be", {28'b0, mem_be}, {28'b0, exp_be});
            if (exp_we) begin
               checkOutput("mem_wdata", mem_wdata, exp_wdata);
            end
         end else begin
            checkOutput("mem_quiet_addr", mem_addr, 32'h0);
            checkOutput("mem_quiet_ctl", {27'b0, mem_we, mem_be}, 32'h0);
            checkOutput("mem_quiet_wdata", mem_wdata, 32'h0);
         end
         if (resp_valid) begin
            checkOutput("resp_rdata", resp_rdata, exp_rdata);
            checkOutput("resp_err", {31'b0, resp_err}, {31'b0, exp_err});
            checkOutput("resp_misaligned", {31'b0, resp_misaligned}, {31'b0, exp_mis});
         end else begin
            checkOutput("resp_quiet", {resp_rdata[31:2], resp_err, resp_misaligned}, 32'h0);
            checkOutput("resp_quiet_lo", {30'b0, resp_rdata[1:0]}, 32'h0);
         end
      end
   end

   // Runs one request end to end. The model works from the RV32I rules:
   // access size, effective lane offset, mask/shift extraction with sign
   // fill, and how many ISSUE cycles the request should hold mem_req.
   // delay = number of ISSUE cycles with mem_ready low before it rises.
   task automatic applyStimulus(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [31:0] rdata, input int delay);
      int          size;
      int          off;
      int          n;
      int          exp_cycles;
      logic        legal;
      logic        mis;
      logic        access;
      logic        tmo;
      logic [31:0] mask;
      logic [31:0] val;

      legal = we ? (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2)
                 : (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
      size  = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
      mis   = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
      mis   = legal && ((size == 2 && addr[0]) || (size == 4 && addr[1:0] != 2'b00));
`endif
      access = legal && !mis;
      tmo    = access && (delay >= TMO);
      off    = (size == 1) ? int'(addr[1:0]) : (size == 2) ? (addr[1] ? 2 : 0) : 0;
      exp_be    = 4'(((1 << size) - 1) << off);
      exp_wdata = (size == 1) ? {4{wdata[7:0]}} : (size == 2) ? {2{wdata[15:0]}} : wdata;
      exp_addr  = {addr[31:2], 2'b00};
      exp_we    = we;
      mask = (size == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * size)) - 32'h1);
      val  = (rdata >> (8 * off)) & mask;
      if (!f3[2] && size < 4 && val[8 * size - 1]) begin
         val = val | ~mask;
      end
      exp_rdata  = (access && !tmo && !we) ? val : 32'h0;
      exp_err    = !legal || tmo;
      exp_mis    = mis;
      exp_cycles = !access ? 0 : (tmo ? TMO : delay + 1);

      @(posedge clk);
      #1;
      checkOutput("req_ready_idle", {31'b0, req_ready}, 32'h1);
      req_valid  = 1'b1;
      req_we     = we;
      req_funct3 = f3;
      req_addr   = addr;
      req_wdata  = wdata;
      @(posedge clk);
      #1;
      req_valid  = 1'b0;
      req_we     = ~we;
      req_funct3 = 3'b111;
      req_addr   = 32'hFFFF_FFFF;
      req_wdata  = ~wdata;

      cap_be    = 4'h0;
      cap_addr  = 32'h0;
      cap_wdata = 32'h0;
      cap_we    = 1'b0;
      n = 0;
      while (mem_req && n < 600) begin
         if (n == 0) begin
            cap_be    = mem_be;
            cap_addr  = mem_addr;
            cap_wdata = mem_wdata;
            cap_we    = mem_we;
         end
         if (n == delay) begin
            mem_ready = 1'b1;
            mem_rdata = rdata;
         end
         @(posedge clk);
         #1;
         mem_ready = 1'b0;
         mem_rdata = 32'hA5A5_5A5A;
         n++;
      end
      cap_cycles = n;
      checkOutput("mem_req_cycles", 32'(n), 32'(exp_cycles));
      checkOutput("resp_valid_latency", {31'b0, resp_valid}, 32'h1);
      cap_rdata = resp_rdata;
      cap_err   = resp_err;
      cap_mis   = resp_misaligned;
      @(posedge clk);
      #1;
      checkOutput("resp_one_cycle", {31'b0, resp_valid}, 32'h0);
      checkOutput("req_ready_back", {31'b0, req_ready}, 32'h1);
   endtask

   // Hard stop in case the DUT wedges the handshake entirely.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   // Directed sequence: reset state, main load/store patterns, timeout and
   // its same-cycle priority, illegal funct3, misalignment, reset abort.
   initial begin
      reset      = 1'b1;
      req_valid  = 1'b0;
      req_we     = 1'b0;
      req_funct3 = 3'b000;
      req_addr   = 32'h0;
      req_wdata  = 32'h0;
      mem_ready  = 1'b0;
      mem_rdata  = 32'hA5A5_5A5A;
      exp_we = 1'b0; exp_addr = 32'h0; exp_be = 4'h0; exp_wdata = 32'h0;
      exp_rdata = 32'h0; exp_err = 1'b0; exp_mis = 1'b0;

      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset_req_ready", {31'b0, req_ready}, 32'h1);
      checkOutput("reset_ctl", {27'b0, mem_req, mem_we, resp_valid, resp_err, resp_misaligned}, 32'h0);
      checkOutput("reset_mem_addr", mem_addr, 32'h0);
      checkOutput("reset_mem_be", {28'b0, mem_be}, 32'h0);
      checkOutput("reset_rdata", resp_rdata, 32'h0);
      reset  = 1'b0;
      chk_en = 1'b1;

      $display("[TB] LB sign-extended upper lane");
      applyStimulus(1'b0, 3'b000, 32'h0000_0103, 32'h0, 32'h80FF_1234, 0);
      checkOutput("lb_be", {28'b0, cap_be}, 32'h8);
      checkOutput("lb_rdata", cap_rdata, 32'hFFFF_FF80);
      checkOutput("lb_cycles", 32'(cap_cycles), 32'd1);

      $display("[TB] SH upper half");
      applyStimulus(1'b1, 3'b001, 32'h0000_0202, 32'h0000_BEEF, 32'h1111_2222, 0);
      checkOutput("sh_be", {28'b0, cap_be}, 32'hC);
      checkOutput("sh_wdata", cap_wdata, 32'hBEEF_BEEF);
      checkOutput("sh_we", {31'b0, cap_we}, 32'h1);
      checkOutput("sh_rdata", cap_rdata, 32'h0);

      $display("[TB] LW timeout");
      applyStimulus(1'b0, 3'b010, 32'h0000_0040, 32'h0, 32'h1234_5678, 1000);
      checkOutput("tmo_cycles", 32'(cap_cycles), 32'd4);
      checkOutput("tmo_err", {31'b0, cap_err}, 32'h1);
      checkOutput("tmo_rdata", cap_rdata, 32'h0);

      $display("[TB] LW ready on the timeout cycle");
      applyStimulus(1'b0, 3'b010, 32'h0000_0040, 32'h0, 32'h1234_5678, 3);
      checkOutput("prio_err", {31'b0, cap_err}, 32'h0);
      checkOutput("prio_rdata", cap_rdata, 32'h1234_5678);

      $display("[TB] illegal load funct3");
      applyStimulus(1'b0, 3'b011, 32'h0000_0010, 32'h0, 32'h0, 0);
      checkOutput("ill_cycles", 32'(cap_cycles), 32'd0);
      checkOutput("ill_err", {31'b0, cap_err}, 32'h1);

      $display("[TB] illegal store funct3");
      applyStimulus(1'b1, 3'b100, 32'h0000_0010, 32'h1, 32'h0, 0);
      checkOutput("ills_err", {31'b0, cap_err}, 32'h1);

      $display("[TB] LW at 0x101");
      applyStimulus(1'b0, 3'b010, 32'h0000_0101, 32'h0, 32'hCAFE_F00D, 1);
`ifdef LSU_MISALIGN_TRAP_EN
      checkOutput("mis_flag", {31'b0, cap_mis}, 32'h1);
      checkOutput("mis_cycles", 32'(cap_cycles), 32'd0);
`else
      checkOutput("mis_addr", cap_addr, 32'h0000_0100);
      checkOutput("mis_be", {28'b0, cap_be}, 32'hF);
      checkOutput("mis_rdata", cap_rdata, 32'hCAFE_F00D);
`endif

      $display("[TB] SB lane 1, LHU/LH/LBU extraction, SW, odd LH");
      applyStimulus(1'b1, 3'b000, 32'h0000_0001, 32'h1234_56A5, 32'h0, 0);
      checkOutput("sb_wdata", cap_wdata, 32'hA5A5_A5A5);
      checkOutput("sb_be", {28'b0, cap_be}, 32'h2);
      applyStimulus(1'b0, 3'b101, 32'h0000_0002, 32'h0, 32'h8001_7FFF, 0);
      checkOutput("lhu_rdata", cap_rdata, 32'h0000_8001);
      applyStimulus(1'b0, 3'b001, 32'h0000_0002, 32'h0, 32'h8001_7FFF, 1);
      checkOutput("lh_rdata", cap_rdata, 32'hFFFF_8001);
      applyStimulus(1'b0, 3'b001, 32'h0000_0000, 32'h0, 32'h8001_7FFF, 0);
      checkOutput("lh_lo_rdata", cap_rdata, 32'h0000_7FFF);
      applyStimulus(1'b0, 3'b100, 32'h0000_0002, 32'h0, 32'h00C3_0000, 0);
      checkOutput("lbu_rdata", cap_rdata, 32'h0000_00C3);
      applyStimulus(1'b1, 3'b010, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0, 2);
      checkOutput("sw_wdata", cap_wdata, 32'hDEAD_BEEF);
      checkOutput("sw_cycles", 32'(cap_cycles), 32'd3);
      applyStimulus(1'b0, 3'b001, 32'h0000_0003, 32'h0, 32'h9876_0000, 0);

      $display("[TB] reset during ISSUE");
      exp_we = 1'b0; exp_addr = 32'h0000_0300; exp_be = 4'hF; exp_wdata = 32'h0;
      exp_rdata = 32'h0; exp_err = 1'b0; exp_mis = 1'b0;
      @(posedge clk);
      #1;
      req_valid  = 1'b1;
      req_we     = 1'b0;
      req_funct3 = 3'b010;
      req_addr   = 32'h0000_0300;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      checkOutput("abort_in_issue", {31'b0, mem_req}, 32'h1);
      reset = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("abort_mem_req", {31'b0, mem_req}, 32'h0);
      checkOutput("abort_resp", {31'b0, resp_valid}, 32'h0);
      checkOutput("abort_ready", {31'b0, req_ready}, 32'h1);
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         checkOutput("abort_no_resp", {30'b0, resp_valid, mem_req}, 32'h0);
      end
      applyStimulus(1'b0, 3'b100, 32'h0000_0000, 32'h0, 32'h0000_00FF, 0);
      checkOutput("post_reset_lbu", cap_rdata, 32'h0000_00FF);

      chk_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
